// File: rtl/vlc_pkg.sv
// rtl/vlc_pkg.sv - shared constants, FSM states and entry layout for the VLC output path
package vlc_pkg;

   localparam int VLC_WORD_W  = 32;
   localparam int VLC_SIZE_W  = 32;
   localparam int VLC_ENTRY_W = VLC_WORD_W + VLC_SIZE_W + 2;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_RUN  = 2'd1,
      ARB_DONE = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic [VLC_WORD_W-1:0] val;
      logic [VLC_SIZE_W-1:0] size;
      logic                  flush;
      logic                  last;
   } vlc_entry_t;

endpackage

// File: rtl/vlc_port_fifo.sv
// rtl/vlc_port_fifo.sv - per-producer synchronous FIFO; push on full succeeds only alongside a pop
module vlc_port_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 66
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap naturally
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/vlc_output_arbiter.sv
// rtl/vlc_output_arbiter.sv - strict-order drain of NUM_PORTS VLC producer FIFOs into one bit writer
// Optional bit statistics (bit_count, port_bits) enabled by VLC_ARB_STATS_EN.
module vlc_output_arbiter
   import vlc_pkg::*;
#(
   parameter int NUM_PORTS  = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic [NUM_PORTS-1:0]      in_enable,
   input  logic [32*NUM_PORTS-1:0]   in_val,
   input  logic [32*NUM_PORTS-1:0]   in_size,
   input  logic [NUM_PORTS-1:0]      in_flush,
   input  logic [NUM_PORTS-1:0]      in_last,
   output logic [NUM_PORTS-1:0]      in_almost_full,
   output logic [NUM_PORTS-1:0]      overflow,
   output logic                      output_enable,
   output logic [VLC_WORD_W-1:0]     val,
   output logic [VLC_SIZE_W-1:0]     size_of_bit,
   output logic                      flush_bit,
   output logic                      busy,
`ifdef VLC_ARB_STATS_EN
   output logic [31:0]               bit_count,
   output logic [32*NUM_PORTS-1:0]   port_bits,
`endif
   output logic                      done
);

   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   arb_state_t              state, state_nxt;
   logic [PW-1:0]           cur_port, cur_port_nxt;
   logic [NUM_PORTS-1:0]    fifo_full, fifo_empty, pop_vec, push_drop;
   logic [VLC_ENTRY_W-1:0]  fifo_dout [NUM_PORTS];
   logic [CW-1:0]           fifo_count [NUM_PORTS];
   vlc_entry_t              head;
   logic                    pop_now;
   logic                    start_ok;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         vlc_port_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(VLC_ENTRY_W)) u_fifo (
            .clock   (clock),
            .reset_n (reset_n),
            .push    (in_enable[gi]),
            .pop     (pop_vec[gi]),
            .din     ({in_val[32*gi +: 32], in_size[32*gi +: 32], in_flush[gi], in_last[gi]}),
            .dout    (fifo_dout[gi]),
            .full    (fifo_full[gi]),
            .empty   (fifo_empty[gi]),
            .count   (fifo_count[gi])
         );
         assign in_almost_full[gi] = (fifo_count[gi] >= CW'(FIFO_DEPTH - 1));
         assign push_drop[gi]      = in_enable[gi] & fifo_full[gi] & ~pop_vec[gi];
      end
   endgenerate

   assign head     = vlc_entry_t'(fifo_dout[cur_port]);
   assign pop_now  = (state == ARB_RUN) && !fifo_empty[cur_port];
   assign pop_vec  = pop_now ? (NUM_PORTS'(1) << cur_port) : '0;
   assign start_ok = (state == ARB_IDLE) && start;
   assign busy     = (state == ARB_RUN);

   always_comb begin
      state_nxt    = state;
      cur_port_nxt = cur_port;
      case (state)
         ARB_IDLE: begin
            if (start) begin
               state_nxt    = ARB_RUN;
               cur_port_nxt = '0;
            end
         end
         ARB_RUN: begin
            if (pop_now && head.last) begin
               if (cur_port == PW'(NUM_PORTS - 1)) state_nxt = ARB_DONE;
               else                                cur_port_nxt = cur_port + PW'(1);
            end
         end
         ARB_DONE: begin
            state_nxt    = ARB_IDLE;
            cur_port_nxt = '0;
         end
         default: begin
            state_nxt    = ARB_IDLE;
            cur_port_nxt = '0;
         end
      endcase
   end

   // done is registered from DONE so it lands one cycle after the final emitted entry
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ARB_IDLE;
         cur_port      <= '0;
         overflow      <= '0;
         done          <= 1'b0;
         output_enable <= 1'b0;
         val           <= '0;
         size_of_bit   <= '0;
         flush_bit     <= 1'b0;
      end else begin
         state         <= state_nxt;
         cur_port      <= cur_port_nxt;
         overflow      <= (start_ok ? '0 : overflow) | push_drop;
         done          <= (state == ARB_DONE);
         output_enable <= pop_now;
         val           <= pop_now ? head.val   : '0;
         size_of_bit   <= pop_now ? head.size  : '0;
         flush_bit     <= pop_now ? head.flush : 1'b0;
      end
   end

`ifdef VLC_ARB_STATS_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bit_count <= '0;
         port_bits <= '0;
      end else if (start_ok) begin
         bit_count <= '0;
         port_bits <= '0;
      end else if (pop_now) begin
         bit_count <= bit_count + head.size;
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (pop_vec[i]) port_bits[32*i +: 32] <= port_bits[32*i +: 32] + head.size;
         end
      end
   end
`endif

endmodule
